dm_resp: RTL and testbench



---
 rtl/dm_resp.sv | 78 +++++++
 tb/tb_dm_resp.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_resp.sv
// dm_resp: word-addressed data RAM responder with programmable wait states
// and a one-cycle ack, serving load/store requests from the core's mem state.
module dm_resp #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 16,
   parameter int DEPTH_LOG2 = 8,
   parameter int WAIT       = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ack,
   output logic              err,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, WAITST, RESP} state_t;
   state_t state, nxt;
   logic [3:0]        cnt;
   logic              l_we;
   logic [ADDR_W-1:0] l_addr;
   logic [DATA_W-1:0] l_wdata;
   logic              go, e_we, e_oor;
   logic [ADDR_W-1:0] e_addr;
   logic [DATA_W-1:0] e_wdata;
   logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];
   always_comb begin
      nxt = IDLE;
      if (state == IDLE)
         nxt = req ? ((WAIT > 0) ? WAITST : RESP) : IDLE;
      else if (state == WAITST)
         nxt = (cnt == 4'd0) ? RESP : WAITST;
   end
   // With no wait states the access completes on the req edge itself, so use the live inputs.
   always_comb begin
      go      = (nxt == RESP);
      e_we    = (state == IDLE) ? we : l_we;
      e_addr  = (state == IDLE) ? addr : l_addr;
      e_wdata = (state == IDLE) ? wdata : l_wdata;
      e_oor   = |e_addr[ADDR_W-1:DEPTH_LOG2];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
         ack   <= 1'b0;
         err   <= 1'b0;
         busy  <= 1'b0;
         rdata <= '0;
      end else begin
         state <= nxt;
         busy  <= (nxt != IDLE);
         ack   <= go;
         cnt   <= (state == IDLE) ? 4'((WAIT > 0) ? WAIT - 1 : 0) :
                  (state == WAITST) ? cnt - 4'd1 : cnt;
         if (go) begin
            err <= e_oor;
            if (!e_we)
               rdata <= e_oor ? '0 : mem[e_addr[DEPTH_LOG2-1:0]];
         end
      end
   end
   always_ff @(posedge clk) begin
      if (state == IDLE && req) begin
         l_we    <= we;
         l_addr  <= addr;
         l_wdata <= wdata;
      end
   end
   // RAM has no reset; out-of-range stores are dropped.
   always_ff @(posedge clk) begin
      if (!rst && go && e_we && !e_oor)
         mem[e_addr[DEPTH_LOG2-1:0]] <= e_wdata;
   end
endmodule

// File: tb/tb_dm_resp.sv
// tb_dm_resp: drives a zero-wait and a two-wait responder side by side and
// checks them against an array model of the RAM and the access timing rules.
module tb_dm_resp;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_v [2];
   logic        we_v [2];
   logic [15:0] addr_v [2];
   logic [31:0] wdata_v [2];
   logic [31:0] rdata_v [2];
   logic        ack_v [2];
   logic        err_v [2];
   logic        busy_v [2];
   logic [31:0] mdl [2][256];
   logic [31:0] lrd [2];
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   dm_resp #(.WAIT(0)) u0 (.clk(clk), .rst(rst), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
      .wdata(wdata_v[0]), .rdata(rdata_v[0]), .ack(ack_v[0]), .err(err_v[0]), .busy(busy_v[0]));
   dm_resp #(.WAIT(2)) u2 (.clk(clk), .rst(rst), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
      .wdata(wdata_v[1]), .rdata(rdata_v[1]), .ack(ack_v[1]), .err(err_v[1]), .busy(busy_v[1]));

   // Index 0 has no wait states, index 1 has two.
   function automatic int wt(input int s);
      return s ? 2 : 0;
   endfunction

   // One access on instance s; returns observed and model-expected results.
   task automatic acc(input int s, input logic w, input logic [15:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat, output int nb,
                      output logic [31:0] x_rd, output logic x_er);
      x_er = (a > 16'd255);
      x_rd = w ? lrd[s] : (x_er ? 32'd0 : mdl[s][a[7:0]]);
      @(negedge clk);
      req_v[s] = 1'b1; we_v[s] = w; addr_v[s] = a; wdata_v[s] = d;
      lat = -1; nb = 0; rd = '0; er = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         req_v[s] = 1'b0;
         if (busy_v[s]) nb++;
         if (ack_v[s]) begin
            lat = k; rd = rdata_v[s]; er = err_v[s];
            break;
         end
      end
      if (w && !x_er) mdl[s][a[7:0]] = d;
      lrd[s] = x_rd;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         req_v[s] = 1'b1; we_v[s] = 1'b1; addr_v[s] = 16'h0001; wdata_v[s] = 32'h1;
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int s = 0; s < 2; s++) req_v[s] = 1'b0;
      for (int s = 0; s < 2; s++) begin
         n_tests++;
         if ({ack_v[s], busy_v[s], err_v[s], rdata_v[s]} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset[%0d]: ack=%b busy=%b err=%b rdata=%h, want all 0", s, ack_v[s], busy_v[s], err_v[s], rdata_v[s]);
         end
      end
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         n_tests++;
         if (busy_v[s] !== 1'b0 || ack_v[s] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_access[%0d]: busy=%b ack=%b, want 0 0", s, busy_v[s], ack_v[s]);
         end
      end
      lrd[0] = '0; lrd[1] = '0;
   endtask

   task automatic test_store_load;
      logic [31:0] rd, x_rd; logic er, x_er; int lat, nb;
      acc(1, 1'b1, 16'h0005, 32'hDEADBEEF, rd, er, lat, nb, x_rd, x_er);
      n_tests++;
      if (lat !== 3 || er !== 1'b0 || nb !== 3) begin
         n_fail++;
         $display("FAIL store_w2: lat=%0d err=%b busy_cycles=%0d, want 3 0 3", lat, er, nb);
      end
      acc(1, 1'b0, 16'h0005, 32'h0, rd, er, lat, nb, x_rd, x_er);
      n_tests++;
      if (rd !== 32'hDEADBEEF || lat !== 3 || nb !== 3 || er !== 1'b0) begin
         n_fail++;
         $display("FAIL load_w2: rdata=%h lat=%0d busy_cycles=%0d err=%b, want deadbeef 3 3 0", rd, lat, nb, er);
      end
   endtask

   task automatic test_wait0;
      logic [31:0] rd, x_rd; logic er, x_er; int lat, nb;
      acc(0, 1'b1, 16'h0000, 32'h12345678, rd, er, lat, nb, x_rd, x_er);
      n_tests++;
      if (lat !== 1 || nb !== 1) begin
         n_fail++;
         $display("FAIL store_w0: lat=%0d busy_cycles=%0d, want 1 1", lat, nb);
      end
      acc(0, 1'b0, 16'h0000, 32'h0, rd, er, lat, nb, x_rd, x_er);
      n_tests++;
      if (rd !== 32'h12345678 || lat !== 1 || er !== 1'b0) begin
         n_fail++;
         $display("FAIL load_w0: rdata=%h lat=%0d err=%b, want 12345678 1 0", rd, lat, er);
      end
   endtask

   task automatic test_back_to_back;
      int acks = 0;
      @(negedge clk);
      req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 16'h0000;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (ack_v[0]) acks++;
         n_tests++;
         if (ack_v[0] !== logic'(k % 2) || (ack_v[0] && rdata_v[0] !== mdl[0][0])) begin
            n_fail++;
            $display("FAIL b2b cycle %0d: ack=%b rdata=%h, want ack=%b rdata=%h", k, ack_v[0], rdata_v[0], logic'(k % 2), mdl[0][0]);
         end
      end
      req_v[0] = 1'b0;
      lrd[0] = mdl[0][0];
      n_tests++;
      if (acks != 5) begin
         n_fail++;
         $display("FAIL b2b_count: acks=%0d, want 5", acks);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_oor;
      logic [31:0] rd, x_rd, d0; logic er, x_er; int lat, nb;
      d0 = $urandom;
      acc(1, 1'b1, 16'h0000, d0, rd, er, lat, nb, x_rd, x_er);
      acc(1, 1'b1, 16'h0100, 32'hFFFFFFFF, rd, er, lat, nb, x_rd, x_er);
      n_tests++;
      if (er !== 1'b1 || lat !== 3) begin
         n_fail++;
         $display("FAIL oor_store: err=%b lat=%0d, want 1 3", er, lat);
      end
      acc(1, 1'b0, 16'h0000, 32'h0, rd, er, lat, nb, x_rd, x_er);
      n_tests++;
      if (rd !== d0 || er !== 1'b0) begin
         n_fail++;
         $display("FAIL oor_no_alias: rdata=%h err=%b, want %h 0", rd, er, d0);
      end
      acc(1, 1'b0, 16'h8000, 32'h0, rd, er, lat, nb, x_rd, x_er);
      n_tests++;
      if (rd !== 32'd0 || er !== 1'b1) begin
         n_fail++;
         $display("FAIL oor_load: rdata=%h err=%b, want 0 1", rd, er);
      end
   endtask

   task automatic test_ignored;
      logic [31:0] rd, x_rd; logic er, x_er; int lat, nb;
      int acks = 0;
      @(negedge clk);
      req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 16'h0010; wdata_v[1] = 32'hA5A5A5A5;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (ack_v[1]) acks++;
         req_v[1] = 1'($urandom); we_v[1] = 1'b1;
         addr_v[1] = 16'($urandom_range(0, 31)); wdata_v[1] = $urandom;
      end
      @(negedge clk);
      req_v[1] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (ack_v[1]) acks++;
         @(negedge clk);
      end
      mdl[1][16] = 32'hA5A5A5A5;
      n_tests++;
      if (acks != 1) begin
         n_fail++;
         $display("FAIL ignored_acks: acks=%0d, want 1", acks);
      end
      acc(1, 1'b0, 16'h0010, 32'h0, rd, er, lat, nb, x_rd, x_er);
      n_tests++;
      if (rd !== 32'hA5A5A5A5) begin
         n_fail++;
         $display("FAIL ignored_data: rdata=%h, want a5a5a5a5", rd);
      end
      acc(1, 1'b0, 16'h0005, 32'h0, rd, er, lat, nb, x_rd, x_er);
      n_tests++;
      if (rd !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL ignored_other: rdata=%h, want deadbeef", rd);
      end
   endtask

   task automatic test_mid_reset;
      logic [31:0] rd, x_rd, prior; logic er, x_er; int lat, nb;
      int acks = 0;
      prior = $urandom;
      acc(1, 1'b1, 16'h0020, prior, rd, er, lat, nb, x_rd, x_er);
      @(negedge clk);
      req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 16'h0020; wdata_v[1] = 32'h0BADF00D;
      @(negedge clk);
      req_v[1] = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      lrd[0] = '0; lrd[1] = '0;
      n_tests++;
      if (busy_v[1] !== 1'b0 || ack_v[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_state: busy=%b ack=%b, want 0 0", busy_v[1], ack_v[1]);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (ack_v[1]) acks++;
      end
      n_tests++;
      if (acks != 0) begin
         n_fail++;
         $display("FAIL midrst_ack: acks=%0d, want 0", acks);
      end
      acc(1, 1'b0, 16'h0020, 32'h0, rd, er, lat, nb, x_rd, x_er);
      n_tests++;
      if (rd !== prior) begin
         n_fail++;
         $display("FAIL midrst_data: rdata=%h, want %h", rd, prior);
      end
   endtask

   task automatic test_random;
      logic [31:0] rd, x_rd; logic er, x_er; int lat, nb, s;
      logic w; logic [15:0] a;
      for (int s0 = 0; s0 < 2; s0++)
         for (int i = 0; i < 8; i++)
            acc(s0, 1'b1, 16'(i), $urandom, rd, er, lat, nb, x_rd, x_er);
      for (int i = 0; i < 40; i++) begin
         s = int'($urandom_range(0, 1));
         w = 1'($urandom);
         a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(256, 65535)) : 16'($urandom_range(0, 7));
         acc(s, w, a, $urandom, rd, er, lat, nb, x_rd, x_er);
         n_tests++;
         if (rd !== x_rd || er !== x_er || lat !== wt(s) + 1 || nb !== wt(s) + 1) begin
            n_fail++;
            $display("FAIL rand[%0d] inst%0d we=%b addr=%h: rdata=%h err=%b lat=%0d busy=%0d, want %h %b %0d %0d",
                     i, s, w, a, rd, er, lat, nb, x_rd, x_er, wt(s) + 1, wt(s) + 1);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         req_v[s] = 1'b0; we_v[s] = 1'b0; addr_v[s] = '0; wdata_v[s] = '0;
      end
      test_reset;
      test_store_load;
      test_wait0;
      test_back_to_back;
      test_oor;
      test_ignored;
      test_mid_reset;
      test_random;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
